// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Multiplexed seven-segment display driver. It scans NUM_DIGITS digits and
//   gives each digit one slot of REFRESH_DIV clocks. The first BLANK_CYCLES
//   clocks of every slot keep all anodes off so the previous digit does not
//   ghost into the next one. New content is captured into a pending buffer
//   and copied to the display buffer only at a frame boundary, so a frame
//   never shows a mix of old and new content.
//
//   Optional build macro SEVEN_SEG_LZ_SUPPRESS_EN: when defined, leading zero
//   digits of the display buffer are blanked. A digit whose decimal point is
//   set stops the suppression, and digit 0 is never suppressed.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   data_in    hex nibbles, nibble i (bits 4i+3:4i) drives digit i
//   dp_in      per-digit decimal point, 1 = lit
//   blank_in   per-digit blank, 1 = digit dark
//   load       pulse: capture data_in/dp_in/blank_in
//   pending    captured content is waiting for the next frame boundary
//   frame_done one-cycle pulse as the last digit slot ends
//   an         anodes, active-low
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   dp         decimal point cathode, active-low
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    slot_end;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_done = slot_end && (idx == IDX_LAST);

    // Stage p0: slot/digit counters and the pending/display buffers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A load on the boundary bypasses the pending buffer entirely.
            if (frame_done && load) begin
                disp_data  <= data_in;
                disp_dp    <= dp_in;
                disp_blank <= blank_in;
                pending    <= 1'b0;
            end else if (frame_done && pending) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pending    <= 1'b0;
            end else if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pending    <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    logic lz_run;
    // Walk down from the top digit; suppression holds until the first
    // non-zero nibble or set decimal point. Digit 0 is outside the walk.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (disp_data[4*i +: 4] != 4'h0 || disp_dp[i])
                lz_run = 1'b0;
            lz_mask[i] = lz_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_sel;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_data[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = disp_blank[i] | lz_mask[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    logic [NUM_DIGITS-1:0] an_p1;
    logic [6:0]            seg_p1;
    logic                  dp_p1;

    // Stage p1: registered pin drive, one cycle behind (cnt, idx)
    always_ff @(posedge clk) begin
        if (reset) begin
            an_p1  <= '1;
            seg_p1 <= 7'h7F;
            dp_p1  <= 1'b1;
        end else if (({1'b0, cnt} < BLANK_END) || cur_blank) begin
            an_p1  <= '1;
            seg_p1 <= 7'h7F;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_sel;
            seg_p1 <= hex_to_seg(cur_nib);
            dp_p1  <= ~cur_dp;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = dp_p1;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver; successor to the fixed 8-digit hex decoder.
- Generalises digit count and refresh rate.
- Adds a prescaled refresh, per-digit decimal points and blanking, anti-ghosting blank time, and tear-free double-buffered updates committed on frame boundaries.
- Sits between the project datapath and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 1..16.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i
- dp_in  input  NUM_DIGITS  per-digit decimal point, 1 = lit
- blank_in  input  NUM_DIGITS  per-digit blank, 1 = digit dark
- load  input  1  pulse; capture data_in/dp_in/blank_in into the pending buffer
- pending  output  1  buffer captured but not yet displayed
- frame_done  output  1  one-cycle pulse when the last digit slot ends
- an  output  NUM_DIGITS  anodes, active-low
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point cathode, active-low

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: an all ones; seg 7'h7F; dp 1; pending 0; frame_done 0; slot counter 0; digit index 0; display and pending buffers 0; display blank mask all ones, so nothing is lit until the first commit.
- Slot counter: cnt counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, idx advances; NUM_DIGITS-1 wraps to 0.
- frame_done: high for exactly the one cycle in which cnt wraps with idx = NUM_DIGITS-1.
- NUM_DIGITS = 1: idx stays 0; frame_done pulses on every slot wrap.
- load: captures all three inputs into the pending buffer and sets pending = 1 on the next edge. A load while pending = 1 overwrites the pending buffer; last load wins.
- Commit: in the frame_done cycle, if pending = 1, copy pending into the display buffer and clear pending.
- load in the frame_done cycle: the new inputs go straight to the display buffer and pending = 0.
- Output registration: an, seg and dp are registered, one cycle after the (cnt, idx) they decode.
  - If cnt < BLANK_CYCLES, or display blank[idx] = 1: an all ones, seg 7'h7F, dp 1.
  - Otherwise: an has only bit idx low; seg = decode(nibble idx); dp = ~dp[idx].
- Decode (full hex, F shown as F):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Reset asserted mid-frame: all state returns to reset values on that edge. Any pending update is lost and the display goes dark.

Optional Feature:
Macro: SEVEN_SEG_LZ_SUPPRESS_EN
- Defined: leading-zero suppression applies to the display buffer. Digits from NUM_DIGITS-1 down to the highest non-zero nibble, exclusive, are treated as blanked. A digit with dp set stops the suppression. Digit 0 is never suppressed, so value 0 shows "0".
- Not defined: all non-blanked digits are shown, including leading zeros.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset, then run 40 cycles with no load -> an=4'hF, seg=7'h7F, dp=1 throughout; frame_done pulses every 16 cycles.
2. Pulse load with data_in=16'h12AF, dp_in=0, blank_in=0 -> pending=1 until the next frame_done, then 0. In the following frame, digit slots 0..3 show seg 0E, 08, 24, 79 with an 1110/1101/1011/0111, each lit 3 of 4 cycles.
3. load 16'h1111, then load 16'h2222 in the same frame -> the next frame shows only "2222"; "1111" is never displayed.
4. load asserted exactly in the frame_done cycle with 16'h3456 -> shown from the very next slot; pending stays 0.
5. blank_in=4'b0100, dp_in=4'b0001 -> digit 2 never lights; dp=0 only during digit 0's lit cycles.
6. Assert reset during slot 2 with pending=1 -> next edge gives an=4'hF, pending=0, idx=0. With SEVEN_SEG_LZ_SUPPRESS_EN defined, 16'h0070 shows digits 0 and 1 only; 16'h0000 shows digit 0 only, as "0".
